// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a two-entry skid buffer, flush/halt override and
// saturating stall/bubble counters. in_ready depends only on registered state.
module psb_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module pipe_stage_buf #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   HALT_PAYLOAD = '0,
  parameter int                 CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             halt_inject,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int NUM_CNT = 2;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Halt overrides flush; both discard any beat handshaking this cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (halt_inject) begin
      state_d = ONE;
      head_d  = HALT_PAYLOAD;
      skid_d  = '0;
    end else if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            head_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            head_d  = '0;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    out_data  = out_valid ? head_q : '0;
  end

  // Counters sample the pre-edge handshake levels regardless of flush/halt.
  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc[0] = out_valid & ~out_ready;
  assign cnt_inc[1] = ~out_valid & out_ready;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    psb_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc[g]),
      .cnt_o (cnt_val[g])
    );
  end

  assign stall_cnt  = cnt_val[0];
  assign bubble_cnt = cnt_val[1];
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, back-pressure, flush, halt,
// counter saturation and asynchronous reset.
module tb_pipe_stage_buf;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam logic [WIDTH-1:0] HALT = 32'h0000_000A;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic             flush, halt_inject, cnt_clr;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(WIDTH), .HALT_PAYLOAD(HALT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .halt_inject(halt_inject), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; halt_inject = 1'b0; cnt_clr = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_od got=%h exp=0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ir got=%b exp=1", in_ready); end
    n_cmp++; if (stall_cnt !== 2'd0 || bubble_cnt !== 2'd0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin n_err++; $display("FAIL stream_out%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ir%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL stream_drain got=%b/%h exp=0/0", out_valid, out_data); end
    n_cmp++; if (stall_cnt !== 2'd0) begin n_err++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    cnt_clr = 1'b1; out_ready = 1'b0;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    n_cmp++; if (out_data !== 32'hA || in_ready !== 1'b1 || stall_cnt !== 2'd0) begin n_err++; $display("FAIL bp_first got=%h/%b/%0d exp=a/1/0", out_data, in_ready, stall_cnt); end
    in_data = 32'hB;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ir got=%b exp=0", in_ready); end
    n_cmp++; if (out_data !== 32'hA || stall_cnt !== 2'd1) begin n_err++; $display("FAIL bp_full got=%h/%0d exp=a/1", out_data, stall_cnt); end
    in_valid = 1'b0; in_data = 32'hEE;
    tick();
    n_cmp++; if (out_data !== 32'hA || stall_cnt !== 2'd2) begin n_err++; $display("FAIL bp_hold got=%h/%0d exp=a/2", out_data, stall_cnt); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB || stall_cnt !== 2'd2) begin n_err++; $display("FAIL bp_rel_b got=%b/%h/%0d exp=1/b/2", out_valid, out_data, stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_rel_ir got=%b exp=1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL bp_empty got=%b/%h exp=0/0", out_valid, out_data); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_pre_ir got=%b exp=0", in_ready); end
    in_data = 32'hC; flush = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin n_err++; $display("FAIL fl_post got=%b/%h/%b exp=0/0/1", out_valid, out_data, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL fl_nolate got=%b/%h exp=0/0", out_valid, out_data); end
  endtask

  task automatic test_halt();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1A;
    tick();
    in_data = 32'h1B;
    tick();
    in_data = 32'h1C; flush = 1'b1; halt_inject = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== HALT) begin n_err++; $display("FAIL halt_load got=%b/%h exp=1/%h", out_valid, out_data, HALT); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL halt_skid got=%b exp=1", in_ready); end
    flush = 1'b0; halt_inject = 1'b0; in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== HALT) begin n_err++; $display("FAIL halt_hold got=%b/%h exp=1/%h", out_valid, out_data, HALT); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_cnt_saturation();
    logic [CNT_W-1:0] exp [6];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3; exp[5] = 2'd3;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    tick();
    n_cmp++; if (bubble_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clr0 got=%0d exp=0", bubble_cnt); end
    cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (bubble_cnt !== exp[i]) begin n_err++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, bubble_cnt, exp[i]); end
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++; if (bubble_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clr got=%0d exp=0", bubble_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h61;
    tick();
    in_data = 32'h62;
    tick();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_out got=%b/%h/%b exp=0/0/1", out_valid, out_data, in_ready); end
    n_cmp++; if (stall_cnt !== 2'd0 || bubble_cnt !== 2'd0) begin n_err++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin n_err++; $display("FAIL arst_first got=%b/%h exp=1/55", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_halt();
    test_cnt_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the in-order MIPS pipeline. It is the successor to the fixed-field ID/EX latch: a WIDTH-bit payload, valid/ready handshaking on both sides, and a two-entry skid buffer so back-pressure never creates a combinational path upstream. It supports bubble insertion (flush) and halt-payload injection, and keeps saturating stall/bubble counters. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's control/data fields packed into the payload.

## Interface
- WIDTH, 32: payload width in bits; legal range ≥1.
- HALT_PAYLOAD, all-zero WIDTH'b0: payload loaded on halt_inject (e.g. syscall-src=1, rs=10 for the halt syscall).
- CNT_W, 16: width of each performance counter; legal range ≥1.
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; a beat transfers when in_valid & in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a beat for downstream.
- out_ready  in  1  downstream accepts; a beat transfers when out_valid & out_ready.
- out_data  out  WIDTH  payload of the head entry; all-zero whenever out_valid=0.
- flush  in  1  branch/jump taken: discard the contents and insert a bubble.
- halt_inject  in  1  replace the contents with HALT_PAYLOAD.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.
- bubble_cnt  out  CNT_W  cycles with !out_valid & out_ready.

## Operation
- Storage: head register (valid and data) plus skid register (valid and data). Occupancy states are EMPTY, ONE and TWO.
- in_ready = !skid_valid. This is registered state only, with no dependence on out_ready, in_valid, flush or halt_inject.
- out_valid = head_valid; out_data = head_data.
- Normal transitions:
  - EMPTY: in fire → ONE, head ← in_data. Otherwise stay in EMPTY.
  - ONE: in fire and out fire → ONE, head ← in_data. Out fire only → EMPTY, head_data ← 0. In fire only → TWO, skid ← in_data. Neither → hold.
  - TWO: out fire → ONE, head ← skid, skid_data ← 0. No in fire is possible here. Otherwise hold.
- Ordering is strict FIFO, with no loss or duplication in normal operation.
- Priority: rst_n > halt_inject > flush > normal.
- flush: head and skid become invalid and their data is zeroed (EMPTY). Any beat that handshakes in the same cycle is dropped. The upstream stage is flushed in the same cycle by the hazard unit.
- halt_inject: head ← HALT_PAYLOAD with valid=1; the skid is cleared; any same-cycle input beat is dropped. Result is ONE. If halt_inject is held, HALT_PAYLOAD is reloaded every cycle.
- Counters:
  - Each counter saturates at 2^CNT_W−1; there is no wrap.
  - cnt_clr zeroes both counters; a same-cycle increment is lost.
  - Counting uses the pre-edge values of out_valid and out_ready, including cycles where flush or halt_inject is active.

## Timing
- Reset (async assert, sync-released by the top level):
  - head and skid are invalid with zero data.
  - out_valid=0, out_data=0, in_ready=1.
  - stall_cnt=0, bubble_cnt=0.
- Latency: a beat accepted at edge N is visible on out_data after edge N (one cycle).
- Throughput: one beat per cycle while out_ready=1.
- When out_ready drops, at most one further beat is absorbed (into the skid). in_ready falls the cycle after the skid fills.
- in_ready rises the cycle after the skid drains.
- flush or halt_inject asserted at edge N takes effect at N: out_valid=0 (flush) or out_data=HALT_PAYLOAD (halt) from N.
- Simultaneous flush and halt_inject: the halt wins.
- rst_n asserted mid-transfer: the state clears immediately, with no clock required.

## Test plan
- Streaming: WIDTH=32, out_ready=1, inputs 0x11, 0x22, 0x33 on consecutive cycles → out_data 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure: fill with 0xA, 0xB while out_ready=0 → in_ready=0 after the second beat; stall_cnt increments each stalled cycle. Release out_ready → 0xA then 0xB in order, and in_ready returns to 1 the cycle after 0xB moves to the head.
- Flush in TWO with in_valid=1 (0xC) → next cycle out_valid=0, out_data=0, in_ready=1; 0xA, 0xB and 0xC never appear.
- halt_inject with flush also high, HALT_PAYLOAD=0x0000_000A → next cycle out_valid=1, out_data=0x0000_000A, skid empty.
- Counter saturation with CNT_W=2: hold out_valid=0 and out_ready=1 for 6 cycles → bubble_cnt reads 1, 2, 3, 3, 3, 3; pulse cnt_clr → 0.
- Async reset asserted between clock edges in state TWO → outputs go to reset values immediately; after release, the first beat 0x55 appears one cycle after acceptance.
